// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types and constants for the sequential multiplier
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int MULT_ITER = 32;

endpackage

// File: rtl/and32.sv
// rtl/and32.sv - 32-bit bitwise AND cell used to gate multiplier partial products
module and32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  assign y = a & b;

endmodule

// File: rtl/mult32_ctrl.sv
// rtl/mult32_ctrl.sv - sequencing FSM and iteration counter for mult32_seq
module mult32_ctrl
  import alu_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic load,
  output logic shift,
  output logic last,
  output logic busy,
  output logic done
);

  mult_state_t      state;
  logic [CNT_W-1:0] count;

  // Operand capture happens on the same edge that accepts start, so load is a decode.
  assign load  = start && (state == IDLE || state == DONE);
  assign shift = (state == CALC);
  assign last  = shift && (count == CNT_W'(MULT_ITER - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= CALC;
            count <= '0;
            busy  <= 1'b1;
          end
        end
        CALC: begin
          count <= count + CNT_W'(1);
          if (count == CNT_W'(MULT_ITER - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= CALC;
            count <= '0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mult32_seq.sv
// rtl/mult32_seq.sv - sequential unsigned 32x32->64 shift-add multiplier
module mult32_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic               load;
  logic               shift;
  logic               last;
  logic [WIDTH-1:0]   m_reg;
  logic [2*WIDTH-1:0] p_reg;
  logic [WIDTH-1:0]   pp;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] p_next;

  mult32_ctrl #(
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .load  (load),
    .shift (shift),
    .last  (last),
    .busy  (busy),
    .done  (done)
  );

  and32 u_and (
    .a (m_reg),
    .b ({WIDTH{p_reg[0]}}),
    .y (pp)
  );

  // The 33-bit sum keeps the carry, which becomes the new MSB after the right shift.
  assign sum    = {1'b0, p_reg[2*WIDTH-1:WIDTH]} + {1'b0, pp};
  assign p_next = {sum, p_reg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reg   <= '0;
      p_reg   <= '0;
      product <= '0;
    end else begin
      if (load) begin
        m_reg <= a;
        p_reg <= {{WIDTH{1'b0}}, b};
      end else if (shift) begin
        p_reg <= p_next;
      end
      // product only ever sees the finished value, never intermediate partial sums.
      if (last) begin
        product <= p_next;
      end
    end
  end

endmodule
